// File: rtl/memory_host_pkg.sv
// memory_host_pkg: command/state encodings, request record and command helpers for memory_host
package memory_host_pkg;

    typedef enum logic [2:0] {
        CMD_NOP        = 3'd0,
        CMD_READ_WORD  = 3'd1,
        CMD_READ_HALF  = 3'd2,
        CMD_READ_BYTE  = 3'd3,
        CMD_WRITE_WORD = 3'd4,
        CMD_WRITE_HALF = 3'd5,
        CMD_WRITE_BYTE = 3'd6,
        CMD_RESERVED   = 3'd7
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        cmd_t        cmd;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    function automatic logic is_write(cmd_t c);
        return c inside {CMD_WRITE_WORD, CMD_WRITE_HALF, CMD_WRITE_BYTE};
    endfunction

    function automatic logic is_word(cmd_t c);
        return c inside {CMD_READ_WORD, CMD_WRITE_WORD};
    endfunction

    function automatic logic is_half(cmd_t c);
        return c inside {CMD_READ_HALF, CMD_WRITE_HALF};
    endfunction

endpackage

// File: rtl/memory_host_if.sv
// memory_host_if: MemoryInterface bus between the core (master) and the memory host (slave)
interface memory_host_if;

    logic [2:0]  cCommand;
    logic [31:0] cAddress;
    logic [31:0] cData;
    logic        hReady;
    logic        hSignal;
    logic [31:0] hData;

    modport master (output cCommand, cAddress, cData, input hReady, hSignal, hData);
    modport slave  (input cCommand, cAddress, cData, output hReady, hSignal, hData);

endinterface

// File: rtl/memory_host_ram.sv
// memory_host_ram: single-port synchronous RAM, 32-bit words with per-byte write enables
module memory_host_ram #(
    parameter int DEPTH_WORDS = 4096,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // registered read of the addressed word; enabled byte lanes written on the same edge
    always_ff @(posedge clock) begin
        rdata <= mem[addr];
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end

endmodule

// File: rtl/memory_host.sv
// memory_host: MemoryInterface responder with wait states and fault flagging over an internal RAM.
// Define MEMORY_HOST_MISALIGN_FAULT_EN to fault misaligned half/word accesses instead of masking.
module memory_host
    import memory_host_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_STATES = 0
) (
    input logic          clock,
    input logic          reset,
    memory_host_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        state, state_nx;
    logic [7:0]    cnt, cnt_nx;
    req_t          req, req_nx;
    cmd_t          cmd_in;
    logic [31:0]   off, rd_val, wdata, h_data, rdata;
    logic [3:0]    be;
    logic [AW-1:0] ram_addr;
    logic          fault, we, h_signal;

    assign cmd_in      = cmd_t'(bus.cCommand);
    assign off         = req.addr - BASE_ADDR;
    assign bus.hReady  = (state == ST_IDLE && cmd_in == CMD_NOP) || state == ST_DONE;
    assign bus.hData   = h_data;
    assign bus.hSignal = h_signal;

    // range, reserved-command and (optionally) alignment faults for the latched request
    always_comb begin
        fault = req.cmd == CMD_RESERVED || req.addr < BASE_ADDR || (off >> 2) >= 32'(DEPTH_WORDS);
`ifdef MEMORY_HOST_MISALIGN_FAULT_EN
        fault = fault || (is_half(req.cmd) && req.addr[0]) || (is_word(req.cmd) && req.addr[1:0] != 2'b00);
`else
        fault = fault || 1'b0;
`endif
    end

    // lane steering: the RAM is read one cycle ahead (from cAddress in IDLE, latched address after)
    // so the word is already in rdata during EXEC; writes replicate data across lanes and enable the addressed ones
    always_comb begin
        ram_addr = state == ST_IDLE ? AW'((bus.cAddress - BASE_ADDR) >> 2) : AW'(off >> 2);
        rd_val   = is_word(req.cmd) ? rdata :
                   is_half(req.cmd) ? {16'h0, 16'(rdata >> {req.addr[1], 4'b0000})} :
                                      {24'h0, 8'(rdata >> {req.addr[1:0], 3'b000})};
        be       = is_word(req.cmd) ? 4'hF :
                   is_half(req.cmd) ? (req.addr[1] ? 4'hC : 4'h3) :
                                      4'b0001 << req.addr[1:0];
        wdata    = is_word(req.cmd) ? req.data :
                   is_half(req.cmd) ? {2{req.data[15:0]}} :
                                      {4{req.data[7:0]}};
        we       = state == ST_EXEC && is_write(req.cmd) && !fault;
    end

    // next-state logic: latch in IDLE, count wait states in BUSY, one EXEC cycle, hold DONE until NOP
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        req_nx   = req;
        case (state)
            ST_IDLE: if (cmd_in != CMD_NOP) begin
                req_nx   = '{cmd: cmd_in, addr: bus.cAddress, data: bus.cData};
                cnt_nx   = 8'(WAIT_STATES);
                state_nx = WAIT_STATES > 0 ? ST_BUSY : ST_EXEC;
            end
            ST_BUSY: begin
                cnt_nx   = cnt - 8'd1;
                state_nx = cnt == 8'd1 ? ST_EXEC : ST_BUSY;
            end
            ST_EXEC: state_nx = ST_DONE;
            ST_DONE: state_nx = cmd_in == CMD_NOP ? ST_IDLE : ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // state, wait counter and latched request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            req   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            req   <= req_nx;
        end
    end

    // response registers, captured in EXEC and held through DONE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_data   <= '0;
            h_signal <= 1'b0;
        end else if (state == ST_EXEC) begin
            h_data   <= fault || is_write(req.cmd) ? 32'h0 : rd_val;
            h_signal <= fault;
        end
    end

    memory_host_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clock (clock),
        .we    (we),
        .be    (be),
        .addr  (ram_addr),
        .wdata (wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_memory_host.sv
// tb_memory_host: directed checks of memory_host with zero and three wait states
module tb_memory_host;
    import memory_host_pkg::*;

    logic clock = 1'b0;
    logic rst0 = 1'b0;
    logic rst3 = 1'b0;
    int   tests = 0;
    int   failed = 0;
    logic [31:0] exp_w;

    memory_host_if b0();
    memory_host_if b3();

    memory_host #(.WAIT_STATES(0)) u0 (.clock(clock), .reset(rst0), .bus(b0));
    memory_host #(.WAIT_STATES(3)) u3 (.clock(clock), .reset(rst3), .bus(b3));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        if (sel) begin
            b3.cCommand = cmd; b3.cAddress = addr; b3.cData = data;
        end else begin
            b0.cCommand = cmd; b0.cAddress = addr; b0.cData = data;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? b3.hReady : b0.hReady;
    endfunction

    function automatic logic [31:0] hdat(input bit sel);
        return sel ? b3.hData : b0.hData;
    endfunction

    function automatic logic hsig(input bit sel);
        return sel ? b3.hSignal : b0.hSignal;
    endfunction

    // present a command, count cycles until hReady, optionally hold it in DONE, then drop to NOP
    task automatic run(input string name, input bit sel, input logic [2:0] cmd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_d, input logic exp_s,
                       input int exp_lat, input int hold);
        int lat;
        logic [31:0] d;
        @(posedge clock); #1;
        drive(sel, cmd, addr, data);
        #1;
        lat = 0;
        while (!rdy(sel) && lat < 50) begin
            @(posedge clock); #2;
            lat++;
        end
        d = hdat(sel);
        check({name, ".lat"}, 32'(lat), 32'(exp_lat));
        check({name, ".data"}, d, exp_d);
        check({name, ".sig"}, {31'b0, hsig(sel)}, {31'b0, exp_s});
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #2;
            check({name, ".hold_rdy"}, {31'b0, rdy(sel)}, 32'd1);
            check({name, ".hold_data"}, hdat(sel), d);
        end
        drive(sel, CMD_NOP, addr, data);
    endtask

    initial begin
        drive(0, CMD_NOP, 32'h0, 32'h0);
        drive(1, CMD_NOP, 32'h0, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        rst0 = 1'b1;
        rst3 = 1'b1;
        #1;
        check("idle_rdy", {31'b0, b0.hReady}, 32'd1);
        check("idle_data", b0.hData, 32'h0);
        check("idle_sig", {31'b0, b0.hSignal}, 32'd0);
        check("idle3_rdy", {31'b0, b3.hReady}, 32'd1);

        run("ww800", 0, CMD_WRITE_WORD, 32'h800, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
        run("rw800", 0, CMD_READ_WORD, 32'h800, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

        run("wb803", 0, CMD_WRITE_BYTE, 32'h803, 32'h000000AA, 32'h0, 1'b0, 2, 0);
        run("rw800b", 0, CMD_READ_WORD, 32'h800, 32'h0, 32'hAAADBEEF, 1'b0, 2, 0);
        run("rh802", 0, CMD_READ_HALF, 32'h802, 32'h0, 32'h0000AAAD, 1'b0, 2, 0);
        run("rh800", 0, CMD_READ_HALF, 32'h800, 32'h0, 32'h0000BEEF, 1'b0, 2, 0);
        run("rb801", 0, CMD_READ_BYTE, 32'h801, 32'h0, 32'h000000BE, 1'b0, 2, 0);
        run("rb803", 0, CMD_READ_BYTE, 32'h803, 32'h0, 32'h000000AA, 1'b0, 2, 0);

        run("ws_w900", 1, CMD_WRITE_WORD, 32'h900, 32'h11223344, 32'h0, 1'b0, 5, 0);
        run("ws_r900", 1, CMD_READ_WORD, 32'h900, 32'h0, 32'h11223344, 1'b0, 5, 3);

        run("w_last", 0, CMD_WRITE_WORD, 32'h3FFC, 32'h55AA55AA, 32'h0, 1'b0, 2, 0);
        run("r_last", 0, CMD_READ_WORD, 32'h3FFC, 32'h0, 32'h55AA55AA, 1'b0, 2, 0);
        run("r_oor", 0, CMD_READ_WORD, 32'h4000, 32'h0, 32'h0, 1'b1, 2, 0);
        run("w_wrap", 0, CMD_WRITE_WORD, 32'hFFFFFFFC, 32'h12345678, 32'h0, 1'b1, 2, 0);
        run("rsvd", 0, CMD_RESERVED, 32'h800, 32'h0, 32'h0, 1'b1, 2, 0);
        run("rw_ok", 0, CMD_READ_WORD, 32'h800, 32'h0, 32'hAAADBEEF, 1'b0, 2, 0);
`ifdef MEMORY_HOST_MISALIGN_FAULT_EN
        run("wh801", 0, CMD_WRITE_HALF, 32'h801, 32'h00001234, 32'h0, 1'b1, 2, 0);
        exp_w = 32'hAAADBEEF;
        run("rw802", 0, CMD_READ_WORD, 32'h802, 32'h0, 32'h0, 1'b1, 2, 0);
`else
        run("wh801", 0, CMD_WRITE_HALF, 32'h801, 32'h00001234, 32'h0, 1'b0, 2, 0);
        exp_w = 32'hAAAD1234;
        run("rw802", 0, CMD_READ_WORD, 32'h802, 32'h0, exp_w, 1'b0, 2, 0);
`endif
        run("rw_after", 0, CMD_READ_WORD, 32'h800, 32'h0, exp_w, 1'b0, 2, 0);

        @(posedge clock); #1;
        drive(1, CMD_WRITE_WORD, 32'h900, 32'h00001234);
        @(posedge clock); #1;
        check("busy_rdy", {31'b0, b3.hReady}, 32'd0);
        rst3 = 1'b0;
        #1;
        check("rst_cmd_rdy", {31'b0, b3.hReady}, 32'd0);
        drive(1, CMD_NOP, 32'h900, 32'h00001234);
        #1;
        check("rst_rdy", {31'b0, b3.hReady}, 32'd1);
        check("rst_data", b3.hData, 32'h0);
        check("rst_sig", {31'b0, b3.hSignal}, 32'd0);
        @(posedge clock); #1;
        rst3 = 1'b1;
        run("rst_r900", 1, CMD_READ_WORD, 32'h900, 32'h0, 32'h11223344, 1'b0, 5, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
